// File: rtl/spi_map_pkg.sv
// Shared SPI register-file map and reader state encoding.
// Addresses below ADDR_CMD_BASE belong to the telemetry writer.
package spi_map_pkg;

    localparam int unsigned ADDR_WHEEL       = 0;
    localparam int unsigned ADDR_BEACON_EDGE = 1;
    localparam int unsigned ADDR_TOWER_POS   = 2;
    localparam int unsigned ADDR_CMD_BASE    = 4;
    localparam int unsigned SPI_NREGS        = 16;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        CAPTURE,
        NEXT
    } rdstate_t;

    function automatic logic [31:0] cmd_addr(input int unsigned base, input int unsigned idx);
        return 32'(base) + 32'(idx);
    endfunction

endpackage

// File: rtl/spi_cmd_reader_if.sv
// Register-file read port shared with the telemetry writer through an arbiter.
interface spi_cmd_reader_if;
    logic        rd_req;
    logic        rd_gnt;
    logic [31:0] rd_addr;
    logic [31:0] rd_data;

    modport master (
        output rd_req,
        output rd_addr,
        input  rd_gnt,
        input  rd_data
    );

    modport slave (
        input  rd_req,
        input  rd_addr,
        output rd_gnt,
        output rd_data
    );
endinterface

// File: rtl/spi_cmd_reader_wdog.sv
// Saturating heartbeat timeout counter; expired is high once LIMIT-1 is reached.
module spi_wdog #(
    parameter int unsigned LIMIT = 5000000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic expired
);
    localparam int CNT_W = (LIMIT > 2) ? $clog2(LIMIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (en && (count_reg != LAST)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign expired = (count_reg == LAST);

endmodule

// File: rtl/spi_cmd_reader.sv
// Polls the Pi command registers round-robin, latches changed words with
// per-word update strobes, and zeroes all commands on heartbeat loss.
module spi_cmd_reader
    import spi_map_pkg::*;
#(
    parameter int unsigned N_CMD       = 4,
    parameter int unsigned BASE_ADDR   = ADDR_CMD_BASE,
    parameter int unsigned RD_LAT      = 1,
    parameter int unsigned WDOG_CYCLES = 5000000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    spi_cmd_reader_if.master     rd,
    output logic [32*N_CMD-1:0]  cmd_data,
    output logic [N_CMD-1:0]     cmd_upd,
    output logic                 cmd_valid,
    output logic                 wdog_trip
);
    localparam int IDX_W = (N_CMD > 1) ? $clog2(N_CMD) : 1;
    localparam int LAT_W = $clog2(RD_LAT + 1);
    localparam logic [IDX_W-1:0] HB_IDX   = IDX_W'(N_CMD - 1);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RD_LAT - 1);

    if ((BASE_ADDR + N_CMD - 1 > SPI_NREGS - 1) || (RD_LAT < 1) || (WDOG_CYCLES < 2)) begin : g_param_bad
        $error("spi_cmd_reader: command window exceeds register space or bad latency/timeout");
    end

    rdstate_t         state_reg;
    logic [IDX_W-1:0] index_reg;
    logic [LAT_W-1:0] lat_reg;
    logic [31:0]      shadow_reg [N_CMD];
    logic [31:0]      cmd_reg    [N_CMD];
    logic [N_CMD-1:0] upd_reg;
    logic             rd_req_reg;
    logic [31:0]      rd_addr_reg;
    logic             cmd_valid_reg;
    logic             trip_reg;

    logic             cap_is_hb;
    logic             cap_changed;
    logic             hb_change;
    logic             trip_now;
    logic             cap_store;
    logic             wd_expired;
    logic [IDX_W-1:0] index_next;

    assign cap_is_hb   = (index_reg == HB_IDX);
    assign cap_changed = (state_reg == CAPTURE) && (rd.rd_data != shadow_reg[index_reg]);
    assign hb_change   = cap_changed && cap_is_hb;
    assign trip_now    = wd_expired && cmd_valid_reg && !hb_change;
    // While tripped only the heartbeat is accepted, so stale command values
    // cannot reappear until the Pi proves it is alive again.
    assign cap_store   = cap_changed && (cap_is_hb || (!trip_reg && !trip_now));
    assign index_next  = cap_is_hb ? '0 : index_reg + 1'b1;

    spi_wdog #(
        .LIMIT (WDOG_CYCLES)
    ) u_wdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (hb_change),
        .en      (enable && cmd_valid_reg),
        .expired (wd_expired)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            index_reg     <= '0;
            lat_reg       <= '0;
            upd_reg       <= '0;
            rd_req_reg    <= 1'b0;
            rd_addr_reg   <= cmd_addr(BASE_ADDR, 0);
            cmd_valid_reg <= 1'b0;
            trip_reg      <= 1'b0;
            for (int i = 0; i < N_CMD; i++) begin
                shadow_reg[i] <= '0;
                cmd_reg[i]    <= '0;
            end
        end else begin
            upd_reg <= '0;
            case (state_reg)
                IDLE: begin
                    if (enable) begin
                        rd_req_reg <= 1'b1;
                        state_reg  <= REQ;
                    end
                end
                REQ: begin
                    if (rd.rd_gnt) begin
                        rd_req_reg <= 1'b0;
                        lat_reg    <= '0;
                        state_reg  <= WAIT;
                    end
                end
                WAIT: begin
                    if (lat_reg == LAT_LAST) begin
                        state_reg <= CAPTURE;
                    end else begin
                        lat_reg <= lat_reg + 1'b1;
                    end
                end
                CAPTURE: begin
                    if (cap_store) begin
                        shadow_reg[index_reg] <= rd.rd_data;
                        cmd_reg[index_reg]    <= rd.rd_data;
                        upd_reg[index_reg]    <= 1'b1;
                    end
                    state_reg <= NEXT;
                end
                NEXT: begin
                    index_reg   <= index_next;
                    rd_addr_reg <= cmd_addr(BASE_ADDR, 32'(index_next));
                    if (enable) begin
                        rd_req_reg <= 1'b1;
                        state_reg  <= REQ;
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase

            // Heartbeat shadow survives a trip so a frozen heartbeat stays tripped.
            if (hb_change) begin
                cmd_valid_reg <= 1'b1;
                trip_reg      <= 1'b0;
            end else if (trip_now) begin
                cmd_valid_reg <= 1'b0;
                trip_reg      <= 1'b1;
                for (int i = 0; i < N_CMD; i++) begin
                    cmd_reg[i] <= '0;
                end
                for (int i = 0; i < N_CMD - 1; i++) begin
                    shadow_reg[i] <= '0;
                end
            end
        end
    end

    for (genvar gi = 0; gi < N_CMD; gi++) begin : g_cmd_out
        assign cmd_data[32*gi +: 32] = cmd_reg[gi];
    end

    assign cmd_upd    = upd_reg;
    assign cmd_valid  = cmd_valid_reg;
    assign wdog_trip  = trip_reg;
    assign rd.rd_req  = rd_req_reg;
    assign rd.rd_addr = rd_addr_reg;

endmodule

// File: tb/tb_spi_cmd_reader.sv
// Directed bench: grant arbiter model, register-file model and an update scoreboard.
module tb_spi_cmd_reader;
    import spi_map_pkg::*;

    localparam int N_CMD  = 4;
    localparam int RD_LAT = 1;
    localparam int WDOG   = 100;

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic                 enable = 1'b0;
    logic [32*N_CMD-1:0]  cmd_data;
    logic [N_CMD-1:0]     cmd_upd;
    logic                 cmd_valid;
    logic                 wdog_trip;

    spi_cmd_reader_if rd_bus();

    logic [31:0] regs [16];
    logic [31:0] delay_addr = 32'hFFFF_FFFF;
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;

    typedef struct {
        int          idx;
        logic [31:0] data;
    } upd_t;
    upd_t exp_q[$];

    spi_cmd_reader #(
        .N_CMD       (N_CMD),
        .BASE_ADDR   (4),
        .RD_LAT      (RD_LAT),
        .WDOG_CYCLES (WDOG)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .rd        (rd_bus),
        .cmd_data  (cmd_data),
        .cmd_upd   (cmd_upd),
        .cmd_valid (cmd_valid),
        .wdog_trip (wdog_trip)
    );

    always #5 clk = ~clk;

    assign rd_bus.rd_data = regs[rd_bus.rd_addr[3:0]];

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic push_upd(input int idx, input logic [31:0] data);
        upd_t e;
        e.idx  = idx;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Arbiter model: grant one cycle after the request is seen, longer for delay_addr.
    initial begin
        int age;
        age = 0;
        rd_bus.rd_gnt = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!reset || rd_bus.rd_gnt) begin
                rd_bus.rd_gnt = 1'b0;
                age = 0;
            end else if (rd_bus.rd_req) begin
                if (age >= ((rd_bus.rd_addr == delay_addr) ? 50 : 1)) rd_bus.rd_gnt = 1'b1;
                age++;
            end else begin
                age = 0;
            end
        end
    end

    // Monitor: grant address order and update strobes against the scoreboard.
    initial begin
        int exp_idx;
        int f;
        exp_idx = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                exp_idx = 0;
            end else begin
                if (rd_bus.rd_req && rd_bus.rd_gnt) begin
                    $display("grant  addr=%0d cycle=%0d", rd_bus.rd_addr, cyc);
                    chk("grant addr", rd_bus.rd_addr, 32'(4 + exp_idx));
                    exp_idx = (exp_idx + 1) % N_CMD;
                end
                for (int i = 0; i < N_CMD; i++) begin
                    if (cmd_upd[i]) begin
                        f = -1;
                        for (int k = 0; k < exp_q.size(); k++)
                            if (f < 0 && exp_q[k].idx == i) f = k;
                        if (f < 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected cmd_upd[%0d]: got data 0x%08h expected no strobe", i, cmd_data[32*i +: 32]);
                        end else begin
                            $display("upd    idx=%0d data=0x%08h cycle=%0d", i, cmd_data[32*i +: 32], cyc);
                            chk("cmd_upd data", cmd_data[32*i +: 32], exp_q[f].data);
                            exp_q.delete(f);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int stable;
        int g_addr;
        int cv_cyc;
        logic [31:0] val;

        for (int i = 0; i < 16; i++) regs[i] = '0;
        reset  = 1'b0;
        enable = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset rd_req", 32'(rd_bus.rd_req), 0);
        chk("reset rd_addr", rd_bus.rd_addr, 4);
        chk("reset cmd_data", 32'(cmd_data == '0), 1);
        chk("reset cmd_upd", 32'(cmd_upd), 0);
        chk("reset cmd_valid", 32'(cmd_valid), 0);
        chk("reset wdog_trip", 32'(wdog_trip), 0);

        // All-zero registers: plain scan, no strobes
        reset  = 1'b1;
        enable = 1'b1;
        repeat (40) @(negedge clk);
        chk("zero scan cmd_data", 32'(cmd_data == '0), 1);
        chk("zero scan cmd_valid", 32'(cmd_valid), 0);

        // Withhold the grant for address 6
        delay_addr = 32'd6;
        n = 0;
        while ((rd_bus.rd_req && rd_bus.rd_addr == 6) && n < 200) begin @(negedge clk); n++; end
        n = 0;
        while (!(rd_bus.rd_req && rd_bus.rd_addr == 6) && n < 200) begin @(negedge clk); n++; end
        chk("addr6 request seen", 32'(rd_bus.rd_req && rd_bus.rd_addr == 6), 1);
        regs[6] = 32'h0000_A5A5;
        push_upd(2, 32'h0000_A5A5);
        stable = 0;
        for (int k = 0; k < 50; k++) begin
            if (rd_bus.rd_req && rd_bus.rd_addr == 6 && !rd_bus.rd_gnt) stable++;
            @(negedge clk);
        end
        chk("held request stable cycles", 32'(stable), 50);
        n = 0;
        while (!rd_bus.rd_gnt && n < 20) begin @(negedge clk); n++; end
        chk("delayed grant seen", 32'(rd_bus.rd_gnt), 1);
        delay_addr = 32'hFFFF_FFFF;
        n = 0;
        do begin @(negedge clk); n++; end while (!cmd_upd[2] && n < 10);
        chk("grant to cmd_upd latency", 32'(n), 32'(RD_LAT + 2));

        // Command word and first heartbeat change
        regs[5] = 32'h0000_1234;
        regs[7] = 32'd1;
        push_upd(1, 32'h0000_1234);
        push_upd(3, 32'd1);
        n = 0;
        while (!cmd_valid && n < 60) begin @(negedge clk); n++; end
        chk("cmd_valid after heartbeat", 32'(cmd_valid), 1);
        cv_cyc = cyc;
        repeat (25) @(negedge clk);
        chk("word1 latched", cmd_data[63:32], 32'h0000_1234);
        chk("word3 heartbeat", cmd_data[127:96], 32'd1);
        chk("no trip while fresh", 32'(wdog_trip), 0);

        // Frozen heartbeat: trip after WDOG cycles
        n = 0;
        while (!wdog_trip && n < 200) begin @(negedge clk); n++; end
        chk("wdog trip seen", 32'(wdog_trip), 1);
        chk("trip delay cycles", 32'(cyc - cv_cyc), 32'(WDOG));
        chk("trip zeroes cmd_data", 32'(cmd_data == '0), 1);
        chk("trip clears cmd_valid", 32'(cmd_valid), 0);
        repeat (30) @(negedge clk);
        chk("stays tripped", 32'(wdog_trip), 1);
        chk("stays zeroed", 32'(cmd_data == '0), 1);

        // Heartbeat resumes
        regs[7] = 32'd2;
        push_upd(3, 32'd2);
        push_upd(1, 32'h0000_1234);
        push_upd(2, 32'h0000_A5A5);
        n = 0;
        while (wdog_trip && n < 40) begin @(negedge clk); n++; end
        chk("trip cleared", 32'(wdog_trip), 0);
        chk("cmd_valid restored", 32'(cmd_valid), 1);
        repeat (30) @(negedge clk);
        chk("word1 restored", cmd_data[63:32], 32'h0000_1234);
        chk("recovery strobes consumed", 32'(exp_q.size()), 0);

        // Drop enable during WAIT
        n = 0;
        while (!(rd_bus.rd_gnt && rd_bus.rd_req && rd_bus.rd_addr != 7) && n < 40) begin @(negedge clk); n++; end
        chk("grant before disable", 32'(rd_bus.rd_gnt), 1);
        g_addr = int'(rd_bus.rd_addr);
        val = 32'hC0DE_0000 | 32'(g_addr);
        regs[g_addr] = val;
        push_upd(g_addr - 4, val);
        @(negedge clk);
        enable = 1'b0;
        stable = 0;
        repeat (150) begin
            @(negedge clk);
            if (rd_bus.rd_req) stable++;
        end
        chk("requests while disabled", 32'(stable), 0);
        chk("in-flight read completed", cmd_data[32*(g_addr-4) +: 32], val);
        chk("watchdog held while disabled", 32'(wdog_trip), 0);
        chk("cmd_valid held while disabled", 32'(cmd_valid), 1);

        // Asynchronous reset during WAIT
        enable = 1'b1;
        n = 0;
        while (!(rd_bus.rd_gnt && rd_bus.rd_req) && n < 30) begin @(negedge clk); n++; end
        chk("grant before reset", 32'(rd_bus.rd_gnt), 1);
        @(negedge clk);
        chk("wait state rd_req low", 32'(rd_bus.rd_req), 0);
        chk("strobes consumed before reset", 32'(exp_q.size()), 0);
        #2 reset = 1'b0;
        #1;
        chk("async reset rd_req", 32'(rd_bus.rd_req), 0);
        chk("async reset rd_addr", rd_bus.rd_addr, 4);
        chk("async reset cmd_data", 32'(cmd_data == '0), 1);
        chk("async reset cmd_upd", 32'(cmd_upd), 0);
        chk("async reset cmd_valid", 32'(cmd_valid), 0);
        chk("async reset wdog_trip", 32'(wdog_trip), 0);
        repeat (2) @(negedge clk);
        for (int i = 0; i < N_CMD; i++)
            if (regs[4+i] != 0) push_upd(i, regs[4+i]);
        reset = 1'b1;
        n = 0;
        while (!rd_bus.rd_req && n < 10) begin @(negedge clk); n++; end
        chk("restart request", 32'(rd_bus.rd_req), 1);
        chk("restart address", rd_bus.rd_addr, 4);
        repeat (40) @(negedge clk);
        chk("post-reset strobes consumed", 32'(exp_q.size()), 0);
        chk("post-reset cmd_valid", 32'(cmd_valid), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
